// File: rtl/mem_sched_pkg.sv
// Shared types and defaults for the round-robin memory scheduler.
// Also carries the coherency encoding reserved for future snoop hooks.
package mem_sched_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_SIZE = 2;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_TIMEOUT   = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        I = 2'b00,
        M = 2'b01,
        S = 2'b10
    } coherency_t;

    // Increment with wrap at n; used to advance the rotation pointer.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module rr_priority_picker
    import mem_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        int j;
        j         = 0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            j = (int'(rr_ptr) + off) % NUM_REQ;
            if (req[j[IDX_W-1:0]]) begin
                grant_idx = j[IDX_W-1:0];
                any_req   = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant[gi] = any_req && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler sharing one memory port between NUM_REQ requesters,
// with a single outstanding command, registered outputs and a hang timeout.
module mem_rr_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_SIZE*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp,
    output logic                          resp_err,
    output logic [DATA_SIZE*8-1:0]        resp_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_SIZE*8-1:0]        mem_wdata,
    input  logic                          mem_ready,
    input  logic                          mem_ack,
    input  logic [DATA_SIZE*8-1:0]        mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int DW    = DATA_SIZE * 8;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    sched_state_t       state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   grant_id_reg, grant_id_next;
    logic [NUM_REQ-1:0] winner_reg, winner_next;
    logic               mem_req_reg, mem_req_next;
    logic               mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [DW-1:0]      mem_wdata_reg, mem_wdata_next;
    logic [NUM_REQ-1:0] resp_reg, resp_next;
    logic               resp_err_reg, resp_err_next;
    logic [DW-1:0]      resp_rdata_reg, resp_rdata_next;
    logic               busy_reg, busy_next;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;
    logic               timeout_hit;
    logic               complete;
    logic               expire;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            cnt_reg        <= '0;
            grant_id_reg   <= '0;
            winner_reg     <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            resp_reg       <= '0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            cnt_reg        <= cnt_next;
            grant_id_reg   <= grant_id_next;
            winner_reg     <= winner_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            resp_reg       <= resp_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        cnt_next        = cnt_reg;
        grant_id_next   = grant_id_reg;
        winner_next     = winner_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        resp_next       = '0;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;
        complete        = 1'b0;
        expire          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_id_next  = pick_idx;
                    winner_next    = pick_grant;
                    mem_we_next    = req_we[pick_idx];
                    mem_addr_next  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    mem_wdata_next = req_wdata[pick_idx*DW +: DW];
                    mem_req_next   = 1'b1;
                    cnt_next       = '0;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (mem_ready && mem_ack) begin
                    complete = 1'b1;
                end else if (timeout_hit) begin
                    expire = 1'b1;
                end else if (mem_ready) begin
                    state_next   = WAIT;
                    mem_req_next = 1'b0;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (mem_ack) begin
                    complete = 1'b1;
                end else if (timeout_hit) begin
                    expire = 1'b1;
                end
            end
            RESP: begin
                state_next  = IDLE;
                rr_ptr_next = IDX_W'(wrap_inc(int'(grant_id_reg), NUM_REQ));
            end
            default: state_next = IDLE;
        endcase

        // An ack landing on the timeout cycle takes precedence over the error.
        if (complete || expire) begin
            state_next      = RESP;
            mem_req_next    = 1'b0;
            resp_next       = winner_reg;
            resp_err_next   = expire;
            resp_rdata_next = (expire || mem_we_reg) ? '0 : mem_rdata;
        end

        busy_next = (state_next != IDLE);
    end

    assign resp       = resp_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign grant_id   = grant_id_reg;
    assign busy       = busy_reg;

endmodule
